// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the shared internal bus mux tree.
// One owner at a time. An owner keeps the bus until it pulses done, drops
// its request or reaches the hold limit. A one-cycle gap always follows an
// owner so the mux select never moves while a grant is active.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no owner, arbitrate on any request
// OWN    | grant active, count hold cycles, watch for release/timeout
// GAP    | break-before-make cycle, grant low, sel frozen; arbitrates like IDLE
module rr_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [NREQ-1:0]  ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic             any_req;
    logic [SEL_W-1:0] winner;
    logic             owner_release;
    logic             hold_expired;
    int               idx;

    // Winner is the first requester above the pointer, wrapping. Scanning
    // from the far end lets the nearest candidate overwrite the others.
    always_comb begin
        any_req = |req;
        winner  = '0;
        idx     = 0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req[idx]) begin
                winner = SEL_W'(idx);
            end
        end
    end

    // Release and timeout conditions for the current owner (indexed by sel).
    always_comb begin
        owner_release = done[sel] | ~req[sel];
        hold_expired  = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    end

    // Ownership state machine with registered grant/sel/busy/timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            grant   <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= PTR_RESET;
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE, S_GAP: begin
                    if (any_req) begin
                        grant <= ONE_HOT0 << winner;
                        sel   <= winner;
                        busy  <= 1'b1;
                        ptr   <= winner;
                        cnt   <= '0;
                        state <= S_OWN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_OWN: begin
                    if (owner_release) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= S_GAP;
                    end else if (hold_expired) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter (NREQ=4, MAX_HOLD=16).
module tb_rr_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_bus_arbiter #(
        .NREQ(4), .SEL_W(2), .MAX_HOLD(16), .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .sel(sel), .busy(busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic b, input logic t);
        check({tag, ".grant"},   32'(grant),   32'(g));
        check({tag, ".sel"},     32'(sel),     32'(s));
        check({tag, ".busy"},    32'(busy),    32'(b));
        check({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] order [5];
        logic [1:0] order_sel [5];
        order     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        order_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;
        #3;
        check_out("por", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // single requester, done pulse, gap, idle
        req = 4'b0001;
        step();
        check_out("t1.grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 4'b0001;
        step();
        check_out("t1.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 4'b0000;
        req  = 4'b0000;
        step();
        check_out("t1.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // all requesting: rotation with one empty cycle between owners
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            check_out($sformatf("t2.own%0d", k), order[k], order_sel[k], 1'b1, 1'b0);
            step();
            check_out($sformatf("t2.hold%0d", k), order[k], order_sel[k], 1'b1, 1'b0);
            done = order[k];
            step();
            check_out($sformatf("t2.gap%0d", k), 4'b0000, order_sel[k], 1'b0, 1'b0);
            done = 4'b0000;
            step();
        end
        req = 4'b0000;
        step();
        check_out("t2.end", 4'b0000, 2'd1, 1'b0, 1'b0);
        step();

        // hold limit on owner 2, then wrapped re-arbitration to owner 1
        do_reset();
        req = 4'b0100;
        step();
        check_out("t3.c0", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0110;
        for (int c = 1; c < 16; c++) begin
            step();
            check_out($sformatf("t3.c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        step();
        check_out("t3.tmo", 4'b0000, 2'd2, 1'b0, 1'b1);
        step();
        check_out("t3.wrap", 4'b0010, 2'd1, 1'b1, 1'b0);

        // foreign done/req activity must not disturb owner 1
        done = 4'b1001;
        step();
        check_out("t4.done", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 4'b0000;
        req  = 4'b0010;
        step();
        check_out("t4.req_lo", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0110;
        step();
        check_out("t4.req_hi", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0100;
        step();
        check_out("t4.rel", 4'b0000, 2'd1, 1'b0, 1'b0);
        step();
        check_out("t5.own", 4'b0100, 2'd2, 1'b1, 1'b0);

        // owner drops request without done; sel frozen until next grant
        req = 4'b0000;
        step();
        check_out("t5.gap", 4'b0000, 2'd2, 1'b0, 1'b0);
        step();
        check_out("t5.idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        step();
        check_out("t5.idle2", 4'b0000, 2'd2, 1'b0, 1'b0);

        // asynchronous reset between edges while owning
        req = 4'b1000;
        step();
        check_out("t6.own", 4'b1000, 2'd3, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("t6.async", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        req = 4'b1010;
        step();
        check_out("t6.restart", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
